// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Fetches one instruction word at a time from instruction memory and hands it
// to the decode stage. The next fetch address comes from the PC unit. There
// is no internal increment. The unit runs one fetch at a time through a
// four-state loop:
//
//   S_REQ  : drive o_mem_req / o_mem_addr until i_mem_gnt
//   S_WAIT : wait for i_mem_rvalid, capture i_mem_rdata
//   S_HOLD : present o_instr / o_pc with o_post_valid until i_post_ready
//   S_NEXT : raise o_pre_ready until i_pre_valid delivers the next PC
//
// The best-case loop takes 4 cycles per instruction. Each stall lengthens
// only the state that is waiting. A handshake input that arrives while the
// FSM is in any other state is ignored.
//
// Parameters
//   RESET_PC      first fetch address after reset
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset (shared with the memory)
//   i_next_pc     next fetch address (valid with i_pre_valid)
//   i_pre_valid   i_next_pc valid
//   o_pre_ready   ifu ready to take i_next_pc (S_NEXT only)
//   o_mem_req     instruction memory request (S_REQ only)
//   o_mem_addr    request address
//   i_mem_gnt     request accepted this cycle
//   i_mem_rvalid  read data valid
//   i_mem_rdata   read instruction word
//   o_pc          address of the fetch that produced o_instr
//   o_instr       delivered instruction word
//   o_post_valid  instruction valid to decode (S_HOLD only)
//   i_post_ready  decode accepts the instruction
//   o_misalign    delivered PC was misaligned
//
// Build option
//   IFU_MISALIGN_CHK_EN
//     Defined: a fetch from a PC with pc[1:0] != 0 issues no memory request.
//       The unit moves to S_HOLD on the next cycle and delivers a nop
//       (32'h0000_0013) with o_misalign = 1.
//     Undefined: the low address bits are dropped on the request, and
//       o_misalign is tied to 0.
// ---------------------------------------------------------------------------
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_next_pc,
  input  logic        i_pre_valid,
  output logic        o_pre_ready,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_post_valid,
  input  logic        i_post_ready,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  // Canonical RISC-V nop (addi x0, x0, 0), delivered in place of a
  // misaligned fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        pc_bad;

  // pc_bad marks a fetch that must not reach memory. Without the check it is
  // constant 0, so the extra paths drop out of the logic.
`ifdef IFU_MISALIGN_CHK_EN
  assign pc_bad = (pc[1:0] != 2'b00);
`else
  assign pc_bad = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_REQ;
    else          state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path driven, so no
  // latch is inferred when a branch does not assign state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (pc_bad)         state_nxt = S_HOLD;
        else if (i_mem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: if (i_mem_rvalid) state_nxt = S_HOLD;
      S_HOLD: if (i_post_ready) state_nxt = S_NEXT;
      S_NEXT: if (i_pre_valid)  state_nxt = S_REQ;
      default:                  state_nxt = S_REQ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake outputs. These decode from state only, and reset gates them
  // combinationally, so they read as 0 while reset is held even before the
  // first clock edge.
  // -------------------------------------------------------------------------
  always_comb begin
    o_mem_req    = 1'b0;
    o_post_valid = 1'b0;
    o_pre_ready  = 1'b0;
    if (i_rst_n) begin
      case (state)
        S_REQ:   o_mem_req    = !pc_bad;
        S_HOLD:  o_post_valid = 1'b1;
        S_NEXT:  o_pre_ready  = 1'b1;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // PC and instruction registers. pc changes only in S_NEXT, and instr only
  // in S_WAIT or on a rejected fetch in S_REQ. Both are therefore stable for
  // the whole of S_HOLD, and o_pc always names the fetch behind o_instr.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      if (state == S_NEXT && i_pre_valid)  pc    <= i_next_pc;
      if (state == S_WAIT && i_mem_rvalid) instr <= i_mem_rdata;
      if (state == S_REQ  && pc_bad)       instr <= NOP_INSTR;
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign;

  // Set together with the substituted nop, and cleared when decode takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      misalign <= 1'b0;
    end else if (state == S_REQ && pc_bad) begin
      misalign <= 1'b1;
    end else if (state == S_HOLD && i_post_ready) begin
      misalign <= 1'b0;
    end
  end

  // Requests only ever leave with an aligned pc, so no masking is needed.
  assign o_mem_addr = pc;
  assign o_misalign = misalign;
`else
  assign o_mem_addr = {pc[31:2], 2'b00};
  assign o_misalign = 1'b0;
`endif

  assign o_pc    = pc;
  assign o_instr = instr;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu
//
// Reference model: the fetch sequence is RESET_PC followed by every next_pc
// that the PC unit hands over. Each address produces one delivery of
// {pc, memory word at the aligned address}, or a nop with misalign set when
// IFU_MISALIGN_CHK_EN is defined and the address is misaligned. Expected
// deliveries are queued when the address is issued. A separate monitor pops
// the queue and compares whenever decode takes an instruction.
// Memory is an associative array with a hash fallback.
// Directed sequences cover reset, the best-case loop, grant and ready
// stalls, reset during a fetch, and misalignment. They are followed by a
// randomized run with random stalls, spurious pulses and occasional resets.
// ---------------------------------------------------------------------------
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pre_valid;
  logic        pre_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        post_valid;
  logic        post_ready;
  logic        misalign;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_next_pc   (next_pc),
    .i_pre_valid (pre_valid),
    .o_pre_ready (pre_ready),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_gnt   (mem_gnt),
    .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata (mem_rdata),
    .o_pc        (pc),
    .o_instr     (instr),
    .o_post_valid(post_valid),
    .i_post_ready(post_ready),
    .o_misalign  (misalign)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_deliv = 0;
  logic [31:0] cur_pc;
  logic [31:0] out_addr;
  bit          outstanding;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[13:0], a[31:14]} ^ 32'h5ac3_96e1;
  endfunction

  function automatic exp_t expect_for(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem_read({p[31:2], 2'b00});
    e.mis   = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    if (p[1:0] != 2'b00) begin
      e.instr = NOP;
      e.mis   = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A reset abandons the fetch in flight. The memory shares the reset, so
  // its outstanding read is dropped as well.
  task automatic reset_model();
    sb.delete();
    outstanding = 1'b0;
    cur_pc      = RESET_PC;
    sb.push_back(expect_for(RESET_PC));
  endtask

  // Runs at the negative edge, when the inputs have been stable for half a
  // cycle. It records the handshakes that the next rising edge will
  // complete.
  task automatic observe();
    if (rst_n === 1'b1) begin
      if (mem_req) check("req_addr", mem_addr, {cur_pc[31:2], 2'b00});
`ifdef IFU_MISALIGN_CHK_EN
      if (cur_pc[1:0] != 2'b00) check("no_req_misaligned", 32'(mem_req), 32'd0);
`endif
      if (mem_req && mem_gnt) begin
        outstanding = 1'b1;
        out_addr    = mem_addr;
      end else if (outstanding && mem_rvalid) begin
        outstanding = 1'b0;
      end
      if (pre_ready && pre_valid) begin
        cur_pc = next_pc;
        sb.push_back(expect_for(next_pc));
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    observe();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  task automatic check_forced_low(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'd0);
    check({tag, "_post_valid"}, 32'(post_valid), 32'd0);
    check({tag, "_pre_ready"},  32'(pre_ready),  32'd0);
  endtask

  // Scoreboard monitor: handshake outputs are mutually exclusive, and each
  // instruction decode takes is checked against the oldest queued fetch.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("excl_outputs", 32'($countones({mem_req, post_valid, pre_ready}) <= 1), 32'd1);
      if (post_valid && post_ready) begin
        n_deliv++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL delivery: got pc %h, expected no delivery (t=%0t)", pc, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("deliv_pc",       pc,             e.pc);
          check("deliv_instr",    instr,          e.instr);
          check("deliv_misalign", 32'(misalign),  32'(e.mis));
        end
      end
    end
  end

  initial begin
    int          req_cyc[$];
    logic [31:0] req_adr[$];

    rst_n      = 1'b0;
    next_pc    = '0;
    pre_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    post_ready = 1'b0;
    mem[RESET_PC] = 32'h0000_0513;
    cur_pc      = RESET_PC;
    out_addr    = RESET_PC;
    outstanding = 1'b0;

    // ---- reset: handshakes forced low, registers at reset values ----
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check_forced_low("rst");
      to_pos();
    end
    to_neg();
    check("rst_pc",       pc,             RESET_PC);
    check("rst_instr",    instr,          32'h0);
    check("rst_misalign", 32'(misalign),  32'd0);
    to_pos();
    rst_n = 1'b1;
    reset_model();

    // ---- best case: every handshake granted on its first cycle ----
    for (int c = 0; c < 8; c++) begin
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = mem_read(out_addr);
      post_ready = 1'b1;
      pre_valid  = 1'b1;
      next_pc    = cur_pc + 32'd4;
      to_neg();
      if (mem_req) begin
        req_cyc.push_back(c);
        req_adr.push_back(mem_addr);
      end
      if (c == 2) begin
        check("bc_post_valid", 32'(post_valid), 32'd1);
        check("bc_pc",         pc,              32'h8000_0000);
        check("bc_instr",      instr,           32'h0000_0513);
      end
      to_pos();
    end
    check("bc_loop_cycles", (req_cyc.size() >= 2) ? 32'(req_cyc[1] - req_cyc[0]) : 32'hffff_ffff, 32'd4);
    check("bc_second_addr", (req_adr.size() >= 2) ? req_adr[1] : 32'hffff_ffff, 32'h8000_0004);

    // ---- grant held low 3 cycles (spurious rvalid present) ----
    for (int i = 0; i < 4; i++) begin
      mem_gnt    = (i == 3);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_read(out_addr);
      post_ready = 1'b1;
      pre_valid  = 1'b1;
      next_pc    = 32'h1234_5678;
      to_neg();
      check("stall_req",  32'(mem_req), 32'd1);
      check("stall_addr", mem_addr,     32'h8000_0008);
      to_pos();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = mem_read(out_addr);
    to_neg();
    check("wait_req", 32'(mem_req), 32'd0);
    to_pos();

    // ---- decode stalls 5 cycles, spurious pre_valid / rvalid / gnt ----
    for (int i = 0; i < 5; i++) begin
      post_ready = 1'b0;
      pre_valid  = 1'b1;
      next_pc    = 32'hdead_0000;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hdead_beef;
      to_neg();
      check("hold_valid", 32'(post_valid), 32'd1);
      check("hold_pc",    pc,              32'h8000_0008);
      check("hold_instr", instr,           mem_read(32'h8000_0008));
      check("hold_req",   32'(mem_req),    32'd0);
      to_pos();
    end
    post_ready = 1'b1;
    pre_valid  = 1'b0;
    cyc();
    pre_valid = 1'b1;
    next_pc   = 32'h8000_000c;
    to_neg();
    check("next_pre_ready", 32'(pre_ready), 32'd1);
    to_pos();

    // ---- reset while waiting for read data; stale rvalid afterwards ----
    pre_valid  = 1'b0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    cyc();
    mem_gnt = 1'b0;
    to_neg();
    check("wait2_req", 32'(mem_req), 32'd0);
    to_pos();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_neg();
      check_forced_low("rst_wait");
      to_pos();
    end
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      mem_gnt    = (i == 2);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_read(32'h8000_000c);
      to_neg();
      check("restart_addr", mem_addr, RESET_PC);
      to_pos();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = mem_read(out_addr);
    cyc();
    mem_rvalid = 1'b0;
    post_ready = 1'b1;
    to_neg();
    check("restart_instr", instr, 32'h0000_0513);
    check("restart_pc",    pc,    RESET_PC);
    to_pos();
    post_ready = 1'b0;
    pre_valid  = 1'b1;
    next_pc    = 32'h8000_0002;
    cyc();
    pre_valid = 1'b0;

    // ---- misaligned next PC ----
    mem_gnt = 1'b1;
    to_neg();
`ifdef IFU_MISALIGN_CHK_EN
    check("mis_req", 32'(mem_req), 32'd0);
    to_pos();
    post_ready = 1'b1;
    to_neg();
    check("mis_valid", 32'(post_valid), 32'd1);
    check("mis_instr", instr,           NOP);
    check("mis_flag",  32'(misalign),   32'd1);
    check("mis_pc",    pc,              32'h8000_0002);
    to_pos();
    post_ready = 1'b0;
    to_neg();
    check("mis_cleared", 32'(misalign), 32'd0);
    to_pos();
`else
    check("mis_req",  32'(mem_req), 32'd1);
    check("mis_addr", mem_addr,     32'h8000_0000);
    to_pos();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = mem_read(out_addr);
    cyc();
    mem_rvalid = 1'b0;
    post_ready = 1'b1;
    to_neg();
    check("mis_pc",    pc,            32'h8000_0002);
    check("mis_instr", instr,         32'h0000_0513);
    check("mis_flag",  32'(misalign), 32'd0);
    to_pos();
    post_ready = 1'b0;
    cyc();
`endif

    // ---- randomized traffic with stalls, spurious pulses, resets ----
    for (int c = 0; c < 4000; c++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
        reset_model();
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
      end
      mem_gnt = ($urandom_range(0, 2) != 0);
      if (outstanding) begin
        mem_rvalid = ($urandom_range(0, 2) != 0);
        mem_rdata  = mem_read(out_addr);
      end else begin
        mem_rvalid = ($urandom_range(0, 4) == 0);
        mem_rdata  = $urandom;
      end
      post_ready = ($urandom_range(0, 2) != 0);
      pre_valid  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       next_pc = $urandom;
        1:       next_pc = cur_pc + 32'd2;
        default: next_pc = cur_pc + 32'd4;
      endcase
      to_neg();
      if (!rst_n) check_forced_low("rnd_rst");
      to_pos();
    end
    check("deliveries_seen", 32'(n_deliv >= 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
